// File: rtl/digi_lock_ctrl_if.sv
// Keypad / actuator bundle for the combination-lock sequencer.
// master = keypad front end and actuator driver side, slave = digi_lock_ctrl.
interface digi_lock_ctrl_if #(
  parameter int KEY_W = 3
);
  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             relock;
  logic             lock;
  logic             alarm;
  logic             busy;
  logic [1:0]       tries_left;

  modport master (
    output key_valid, key_in, relock,
    input  lock, alarm, busy, tries_left
  );

  modport slave (
    input  key_valid, key_in, relock,
    output lock, alarm, busy, tries_left
  );
endinterface

// File: rtl/digi_lock_ctrl.sv
// 3-digit combination lock sequencer: digit compare, tries counter, timed relock and alarm lockout.
// Latency 1 cycle from the final strobe to lock/alarm; no backpressure, one digit per strobe.
// Optional DIGI_LOCK_PROG_EN: a new code can be keyed in while open.
module digi_lock_ctrl #(
  parameter int               KEY_W       = 3,
  parameter logic [KEY_W-1:0] CODE0       = 3'b001,
  parameter logic [KEY_W-1:0] CODE1       = 3'b101,
  parameter logic [KEY_W-1:0] CODE2       = 3'b011,
  parameter int               MAX_TRIES   = 3,
  parameter int               UNLOCK_CYC  = 8,
  parameter int               LOCKOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           rst,
  digi_lock_ctrl_if.slave bus
);

  localparam int         TMAX       = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int         TW         = $clog2(TMAX + 1);
  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

  typedef enum logic [2:0] {K0, K1, K2, OPEN, LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic            mism_q, mism_d;
  logic [1:0]      tries_q, tries_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            lock_q, alarm_q;
  logic [KEY_W-1:0] exp_dig;
  logic [KEY_W-1:0] code0_w, code1_w, code2_w;
  logic            dig_bad;

`ifdef DIGI_LOCK_PROG_EN
  logic [KEY_W-1:0] code0_q, code1_q, code2_q;
  logic [KEY_W-1:0] code0_d, code1_d, code2_d;
  logic [KEY_W-1:0] sh0_q, sh1_q, sh0_d, sh1_d;
  logic [1:0]       sh_cnt_q, sh_cnt_d;

  assign code0_w = code0_q;
  assign code1_w = code1_q;
  assign code2_w = code2_q;
`else
  assign code0_w = CODE0;
  assign code1_w = CODE1;
  assign code2_w = CODE2;
`endif

  always_comb begin
    exp_dig = code0_w;
    case (state_q)
      K1:      exp_dig = code1_w;
      K2:      exp_dig = code2_w;
      default: exp_dig = code0_w;
    endcase
  end

  assign dig_bad = (bus.key_in != exp_dig);

  always_comb begin
    state_d = state_q;
    mism_d  = mism_q;
    tries_d = tries_q;
    timer_d = timer_q;
`ifdef DIGI_LOCK_PROG_EN
    code0_d  = code0_q;
    code1_d  = code1_q;
    code2_d  = code2_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh_cnt_d = sh_cnt_q;
`endif
    case (state_q)
      K0: if (bus.key_valid) begin
        mism_d  = mism_q | dig_bad;
        state_d = K1;
      end
      K1: if (bus.key_valid) begin
        mism_d  = mism_q | dig_bad;
        state_d = K2;
      end
      // All three digits are consumed before judging, so a wrong digit's position stays hidden.
      K2: if (bus.key_valid) begin
        mism_d = 1'b0;
        if (!mism_q && !dig_bad) begin
          state_d = OPEN;
          tries_d = TRIES_INIT;
          timer_d = TW'(UNLOCK_CYC);
        end else begin
          tries_d = tries_q - 2'd1;
          if (tries_q == 2'd1) begin
            state_d = LOCKOUT;
            timer_d = TW'(LOCKOUT_CYC);
          end else begin
            state_d = K0;
          end
        end
      end
      OPEN: begin
`ifdef DIGI_LOCK_PROG_EN
        // Relock beats a programming strobe; a strobe keeps the lock open.
        if (bus.relock) begin
          state_d  = K0;
          timer_d  = '0;
          sh_cnt_d = 2'd0;
        end else if (bus.key_valid) begin
          if (sh_cnt_q == 2'd2) begin
            code0_d  = sh0_q;
            code1_d  = sh1_q;
            code2_d  = bus.key_in;
            state_d  = K0;
            timer_d  = '0;
            sh_cnt_d = 2'd0;
          end else begin
            if (sh_cnt_q == 2'd0) sh0_d = bus.key_in;
            else                  sh1_d = bus.key_in;
            sh_cnt_d = sh_cnt_q + 2'd1;
            timer_d  = TW'(UNLOCK_CYC);
          end
        end else if (timer_q == TW'(1)) begin
          state_d  = K0;
          timer_d  = '0;
          sh_cnt_d = 2'd0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
`else
        if (bus.relock || timer_q == TW'(1)) begin
          state_d = K0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
`endif
      end
      LOCKOUT: begin
        if (timer_q == TW'(1)) begin
          state_d = K0;
          timer_d = '0;
          tries_d = TRIES_INIT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = K0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= K0;
      mism_q  <= 1'b0;
      tries_q <= TRIES_INIT;
      timer_q <= '0;
      lock_q  <= 1'b1;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mism_q  <= mism_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      lock_q  <= (state_d != OPEN);
      alarm_q <= (state_d == LOCKOUT);
    end
  end

`ifdef DIGI_LOCK_PROG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      code0_q  <= CODE0;
      code1_q  <= CODE1;
      code2_q  <= CODE2;
      sh0_q    <= '0;
      sh1_q    <= '0;
      sh_cnt_q <= 2'd0;
    end else begin
      code0_q  <= code0_d;
      code1_q  <= code1_d;
      code2_q  <= code2_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end
`endif

  assign bus.lock       = lock_q;
  assign bus.alarm      = alarm_q;
  assign bus.busy       = (state_q == K1) || (state_q == K2);
  assign bus.tries_left = tries_q;

endmodule

// File: tb/tb_digi_lock_ctrl.sv
// Scoreboard bench for digi_lock_ctrl: directed scenarios then random keying against a sequence-level model.
module tb_digi_lock_ctrl;
  localparam int       KW = 3;
  localparam logic [2:0] C0 = 3'b001;
  localparam logic [2:0] C1 = 3'b101;
  localparam logic [2:0] C2 = 3'b011;
  localparam int       MT = 3;
  localparam int       UC = 8;
  localparam int       LC = 16;

  typedef struct packed {
    logic       lock;
    logic       alarm;
    logic       busy;
    logic [1:0] tries;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digi_lock_ctrl_if #(.KEY_W(KW)) bus ();

  digi_lock_ctrl #(
    .KEY_W(KW), .CODE0(C0), .CODE1(C1), .CODE2(C2),
    .MAX_TRIES(MT), .UNLOCK_CYC(UC), .LOCKOUT_CYC(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: whole entered sequences are compared against the code.
  logic [2:0] m_code [3];
  logic [2:0] m_entry [$];
  logic [2:0] m_shadow [$];
  bit         m_open, m_lockout;
  int         m_left, m_fails;

  exp_t expq [$];
  int   checks = 0;
  int   errors = 0;

  task automatic m_reset();
    m_code[0] = C0; m_code[1] = C1; m_code[2] = C2;
    m_entry.delete();
    m_shadow.delete();
    m_open = 0; m_lockout = 0; m_left = 0; m_fails = 0;
  endtask

  task automatic m_close();
    m_open = 0;
    m_shadow.delete();
  endtask

  task automatic m_step(input bit r, input bit kv, input logic [2:0] k, input bit rl);
    if (r) begin
      m_reset();
    end else if (m_open) begin
`ifdef DIGI_LOCK_PROG_EN
      if (rl) m_close();
      else if (kv) begin
        m_shadow.push_back(k);
        if (m_shadow.size() == 3) begin
          for (int i = 0; i < 3; i++) m_code[i] = m_shadow[i];
          m_close();
        end else m_left = UC;
      end else if (m_left == 1) m_close();
      else m_left--;
`else
      if (rl || m_left == 1) m_close();
      else m_left--;
`endif
    end else if (m_lockout) begin
      if (m_left == 1) begin m_lockout = 0; m_fails = 0; end
      else m_left--;
    end else if (kv) begin
      m_entry.push_back(k);
      if (m_entry.size() == 3) begin
        if (m_entry[0] == m_code[0] && m_entry[1] == m_code[1] && m_entry[2] == m_code[2]) begin
          m_open = 1; m_left = UC; m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MT) begin m_lockout = 1; m_left = LC; end
        end
        m_entry.delete();
      end
    end
  endtask

  function automatic exp_t m_out();
    exp_t e;
    e.lock  = !m_open;
    e.alarm = m_lockout;
    e.busy  = !m_open && !m_lockout && (m_entry.size() > 0);
    e.tries = 2'(MT - m_fails);
    return e;
  endfunction

  task automatic drive(input bit r, input bit kv, input logic [2:0] k, input bit rl);
    rst = r; bus.key_valid = kv; bus.key_in = k; bus.relock = rl;
    m_step(r, kv, k, rl);
    expq.push_back(m_out());
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [2:0] k);
    drive(0, 1, k, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 3'b000, 0);
  endtask

  task automatic enter(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    key(a); key(b); key(c);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("lock",       {1'b0, bus.lock},  {1'b0, e.lock});
        chk("alarm",      {1'b0, bus.alarm}, {1'b0, e.alarm});
        chk("busy",       {1'b0, bus.busy},  {1'b0, e.busy});
        chk("tries_left", bus.tries_left,    e.tries);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [2:0] d;
    bit         kv, rl, r;
    m_reset();
    drive(1, 0, 3'b000, 0);
    drive(1, 0, 3'b000, 0);

    enter(C0, C1, C2); idle(12);
    enter(3'b001, 3'b111, 3'b011); enter(C0, C1, C2); idle(10);

    enter(3'b000, 3'b000, 3'b000);
    enter(3'b000, 3'b000, 3'b000);
    enter(3'b000, 3'b000, 3'b000);
    enter(C0, C1, C2);
    idle(14);
    enter(C0, C1, C2); idle(10);

    enter(C0, C1, C2); idle(2); drive(0, 0, 3'b000, 1); idle(2);
    key(C0); drive(0, 0, 3'b000, 1); key(C1); key(C2); idle(10);

    enter(C0, C1, C2); idle(3); drive(1, 0, 3'b000, 0); idle(2);
    enter(3'b000, 3'b000, 3'b000);
    enter(3'b000, 3'b000, 3'b000);
    enter(3'b000, 3'b000, 3'b000);
    idle(4); drive(1, 0, 3'b000, 0); idle(2);
    enter(C0, C1, C2); idle(10);

`ifdef DIGI_LOCK_PROG_EN
    enter(C0, C1, C2); idle(1);
    enter(3'b110, 3'b010, 3'b111); idle(2);
    enter(C0, C1, C2);
    enter(3'b110, 3'b010, 3'b111); idle(10);
    drive(1, 0, 3'b000, 0);
`endif

    for (int n = 0; n < 2000; n++) begin
      kv = ($urandom_range(0, 1) == 1);
      rl = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0 || m_entry.size() > 2) d = 3'($urandom_range(0, 7));
      else d = m_code[m_entry.size()];
      drive(r, kv, d, rl);
    end
    idle(2);

    @(negedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
